// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and flush controls
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q <= '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, fetch FSM and skid feeding the IF/ID register
// Optional FETCH_PERF_EN adds fetched/stall/flush performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction_out,
    output logic [31:0] PC_out,
    output logic        valid_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  stale_q, stale_d;
    ifid_t        skid_q, skid_d;
    ifid_t        ifid_q, ifid_d;
    logic         ifid_load, ifid_flush;
    logic         fetch_accept;
    logic [31:0]  pc_next;

    assign pc_next = pc_q + 32'd4;

    // Request lines depend only on registered state; rst merely masks them.
    assign imem_req  = !rst && (state_q != HOLD);
    assign imem_addr = (state_q == KILL) ? stale_q : pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            stale_q <= 32'h0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stale_d      = stale_q;
        skid_d       = skid_q;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        ifid_d       = '{instr: NOP_INSTR, pc: ifid_q.pc, valid: 1'b0};
        fetch_accept = 1'b0;
        if (branch_taken) begin
            ifid_flush = 1'b1;
            skid_d     = '0;
            pc_d       = branch_addr;
            // An unanswered request must still be drained before refetching.
            if (state_q == FETCH && !imem_ack) begin
                state_d = KILL;
                stale_d = pc_q;
            end else if (state_q == KILL && !imem_ack) begin
                state_d = KILL;
            end else begin
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        fetch_accept = 1'b1;
                        pc_d         = pc_next;
                        if (freeze) begin
                            skid_d  = '{instr: imem_rdata, pc: pc_next, valid: 1'b1};
                            state_d = HOLD;
                        end else begin
                            ifid_load = 1'b1;
                            ifid_d    = '{instr: imem_rdata, pc: pc_next, valid: 1'b1};
                        end
                    end else if (!freeze) begin
                        ifid_load = 1'b1;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        ifid_load = 1'b1;
                        ifid_d    = skid_q;
                        skid_d    = '0;
                        state_d   = FETCH;
                    end
                end
                KILL: begin
                    if (imem_ack) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (ifid_load),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign Instruction_out = ifid_q.instr;
    assign PC_out          = ifid_q.pc;
    assign valid_out       = ifid_q.valid;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= 32'h0;
            perf_stall   <= 32'h0;
            perf_flush   <= 32'h0;
        end else begin
            if (fetch_accept) perf_fetched <= perf_fetched + 32'd1;
            if (imem_req && !imem_ack) perf_stall <= perf_stall + 32'd1;
            if (branch_taken) perf_flush <= perf_flush + 32'd1;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = fetch_accept;
`endif

endmodule
